// File: rtl/serial_adder_if.sv
// Handshake bundle between an operand producer, the serial_adder and a result consumer.
// Optional signed-overflow flag is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, built from two half adders
// and a carry flop. Result {cout,sum} = a + b + cin, presented after WIDTH cycles.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.

// Single-bit half adder.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
    logic carry_nxt, accept, last_bit;

    half_adder u_ha0 (.a_i(a_q[0]),  .b_i(b_q[0]),  .sum_o(ha0_sum), .carry_o(ha0_carry));
    half_adder u_ha1 (.a_i(ha0_sum), .b_i(carry_q), .sum_o(ha1_sum), .carry_o(ha1_carry));

    assign carry_nxt = ha0_carry | ha1_carry;
    assign accept    = bus.in_valid && (state_q == IDLE);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; DONE always returns to IDLE so an accept can never share the handoff cycle.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = ADD;
            ADD:     if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath next-state: load on accept, shift one bit per ADD cycle, hold otherwise.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == ADD) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {ha1_sum, sum_q[WIDTH-1:1]};
            carry_d = carry_nxt;
            if (last_bit) begin
                cout_d = carry_nxt;
                cnt_d  = '0;
`ifdef SERIAL_ADDER_OVF_EN
                // On the last bit a_q[0]/b_q[0] are the operand MSBs captured at accept.
                ovf_d  = (a_q[0] == b_q[0]) && (ha1_sum != a_q[0]);
`endif
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
